// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels, field widths.
package i2c_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrite,
      StWriteAck,
      StRead,
      StReadAck,
      StWaitStop
   } i2c_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// Fabric-side handshake between the I2C target and the logic it serves.
interface i2c_target_if;
   import i2c_pkg::*;

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_load;
   logic              rw;
   logic              busy;

   // slave: the I2C target block; master: the fabric consuming/supplying bytes
   modport slave (
      output rx_data,
      output rx_valid,
      input  tx_data,
      output tx_load,
      output rw,
      output busy
   );

   modport master (
      input  rx_data,
      input  rx_valid,
      output tx_data,
      input  tx_load,
      input  rw,
      input  busy
   );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives edge and START/STOP pulses.
module i2c_bus_sync (
   input  logic i_clk,
   input  logic i_rst,      // synchronous, active-low
   input  logic i_scl,
   input  logic i_sda,
   output logic o_sda,      // synchronized SDA level
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   // [0],[1] form the 2-FF synchronizer, [2] holds the previous synced sample
   logic [2:0] r_scl_sync;
   logic [2:0] r_sda_sync;

   // Shift raw lines through the synchronizer chain; idle bus level is high
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_scl_sync <= 3'b111;
         r_sda_sync <= 3'b111;
      end else begin
         r_scl_sync <= {r_scl_sync[1:0], i_scl};
         r_sda_sync <= {r_sda_sync[1:0], i_sda};
      end
   end

   assign o_sda      = r_sda_sync[1];
   assign o_scl_rise =  r_scl_sync[1] & ~r_scl_sync[2];
   assign o_scl_fall = ~r_scl_sync[1] &  r_scl_sync[2];
   // SDA moving while SCL stays high marks START (fall) or STOP (rise)
   assign o_start = r_scl_sync[1] & r_scl_sync[2] & ~r_sda_sync[1] &  r_sda_sync[2];
   assign o_stop  = r_scl_sync[1] & r_scl_sync[2] &  r_sda_sync[1] & ~r_sda_sync[2];

endmodule

// File: rtl/i2c_target.sv
// 7-bit-address I2C target: address match, write byte delivery, read byte serialization.
// No clock stretching; SDA is only ever pulled low or released.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] OWN_ADDR = 7'h50
) (
   input  logic         i_clk,
   input  logic         i_rst,   // synchronous, active-low
   input  logic         i_scl,
   inout  wire          io_sda,
   i2c_target_if.slave  bus
);

   logic w_sda;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;

   i2c_bus_sync u_sync (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_scl      (i_scl),
      .i_sda      (io_sda),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   i2c_state_e        r_state;
   logic [2:0]        r_bit_cnt;
   logic [ADDR_W-1:0] r_shift;      // first 7 bits of the byte being received
   logic [DATA_W-1:0] r_tx_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_pend;    // delays rx_valid one clk behind rx_data
   logic              r_rx_valid;
   logic              r_tx_load;
   logic              r_rw;
   logic              r_busy;
   logic              r_drive_low;
   // In ACK states: SDA low already driven. In StRead: MSB due on next fall.
   logic              r_ack_on;

   logic [DATA_W-1:0] w_byte;
   assign w_byte = {r_shift, w_sda};

   // Protocol FSM with all outputs registered; START/STOP override every state
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= StIdle;
         r_bit_cnt   <= 3'd0;
         r_shift     <= '0;
         r_tx_shift  <= '0;
         r_rx_data   <= '0;
         r_rx_pend   <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_tx_load   <= 1'b0;
         r_rw        <= 1'b0;
         r_busy      <= 1'b0;
         r_drive_low <= 1'b0;
         r_ack_on    <= 1'b0;
      end else begin
         r_rx_valid <= r_rx_pend;
         r_rx_pend  <= 1'b0;
         r_tx_load  <= 1'b0;
         if (w_start) begin
            r_state     <= StAddr;
            r_bit_cnt   <= 3'd0;
            r_busy      <= 1'b0;
            r_drive_low <= 1'b0;
            r_ack_on    <= 1'b0;
         end else if (w_stop) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_drive_low <= 1'b0;
            r_ack_on    <= 1'b0;
         end else begin
            unique case (r_state)
               StAddr: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte[ADDR_W-1:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        // Address 0 (general call) is never acknowledged
                        if (r_shift == OWN_ADDR && r_shift != '0) begin
                           r_state  <= StAddrAck;
                           r_rw     <= w_sda;
                           r_busy   <= 1'b1;
                           r_ack_on <= 1'b0;
                        end else begin
                           r_state <= StWaitStop;
                        end
                     end
                  end
               end
               StAddrAck: begin
                  if (w_scl_fall) begin
                     if (!r_ack_on) begin
                        r_ack_on    <= 1'b1;
                        r_drive_low <= 1'b1;
                        if (r_rw) begin
                           r_tx_load  <= 1'b1;
                           r_tx_shift <= bus.tx_data;
                        end
                     end else begin
                        r_ack_on <= 1'b0;
                        if (r_rw) begin
                           // The fall ending the ACK also launches the MSB
                           r_state     <= StRead;
                           r_drive_low <= ~r_tx_shift[DATA_W-1];
                           r_tx_shift  <= {r_tx_shift[DATA_W-2:0], 1'b0};
                           r_bit_cnt   <= 3'd1;
                        end else begin
                           r_state     <= StWrite;
                           r_drive_low <= 1'b0;
                           r_bit_cnt   <= 3'd0;
                        end
                     end
                  end
               end
               StWrite: begin
                  if (w_scl_rise) begin
                     r_shift   <= w_byte[ADDR_W-1:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_rx_data <= w_byte;
                        r_rx_pend <= 1'b1;
                        r_state   <= StWriteAck;
                        r_ack_on  <= 1'b0;
                     end
                  end
               end
               StWriteAck: begin
                  if (w_scl_fall) begin
                     if (!r_ack_on) begin
                        r_ack_on    <= 1'b1;
                        r_drive_low <= 1'b1;
                     end else begin
                        r_ack_on    <= 1'b0;
                        r_drive_low <= 1'b0;
                        r_state     <= StWrite;
                     end
                  end
               end
               StRead: begin
                  if (w_scl_fall) begin
                     if (r_ack_on || r_bit_cnt != 3'd0) begin
                        r_ack_on    <= 1'b0;
                        r_drive_low <= ~r_tx_shift[DATA_W-1];
                        r_tx_shift  <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt   <= r_bit_cnt + 3'd1;
                     end else begin
                        // Counter wrapped: all 8 bits out, hand SDA to initiator
                        r_drive_low <= 1'b0;
                        r_state     <= StReadAck;
                     end
                  end
               end
               StReadAck: begin
                  if (w_scl_rise) begin
                     if (w_sda == ACK) begin
                        r_tx_load  <= 1'b1;
                        r_tx_shift <= bus.tx_data;
                        r_bit_cnt  <= 3'd0;
                        r_ack_on   <= 1'b1;
                        r_state    <= StRead;
                     end else begin
                        r_state <= StWaitStop;
                     end
                  end
               end
               StIdle, StWaitStop: begin
                  r_drive_low <= 1'b0;
               end
               default: begin
                  r_state     <= StIdle;
                  r_drive_low <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_sda       = r_drive_low ? 1'b0 : 1'bz;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.tx_load  = r_tx_load;
   assign bus.rw       = r_rw;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: BFM initiator at SCL = clk/16, scoreboard for written bytes.
module tb_i2c_target;

   logic r_clk = 1'b0;
   logic r_rst;
   logic r_scl;
   logic r_m_sda_low;
   wire  w_sda;

   pullup (w_sda);
   assign w_sda = r_m_sda_low ? 1'b0 : 1'bz;

   i2c_target_if u_bus ();

   i2c_target #(
      .OWN_ADDR (7'h50)
   ) u_dut (
      .i_clk  (r_clk),
      .i_rst  (r_rst),
      .i_scl  (r_scl),
      .io_sda (w_sda),
      .bus    (u_bus.slave)
   );

   always #5 r_clk = ~r_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_rx     = 0;
   int n_load   = 0;
   logic [7:0] q_rx[$];
   logic [7:0] m_rx_last = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each rx_valid pulse must match the oldest byte written on the bus
   always @(negedge r_clk) begin
      if (r_rst === 1'b1 && u_bus.rx_valid === 1'b1) begin
         n_rx++;
         if (q_rx.size() == 0) begin
            check("rx_unexpected", 32'(u_bus.rx_data), 32'hFFFF_FFFF);
         end else begin
            check("rx_data_sb", 32'(u_bus.rx_data), 32'(q_rx.pop_front()));
         end
      end
      if (r_rst === 1'b1 && u_bus.tx_load === 1'b1) n_load++;
   end

   initial begin
      #500_000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge r_clk);
      #1;
   endtask

   // Works from idle (SCL high) or mid-transfer (SCL low) for repeated START
   task automatic bus_start();
      r_m_sda_low = 1'b0;
      wait_clk(4);
      r_scl = 1'b1;
      wait_clk(8);
      r_m_sda_low = 1'b1;
      wait_clk(8);
      r_scl = 1'b0;
      wait_clk(4);
   endtask

   task automatic bus_stop();
      r_m_sda_low = 1'b1;
      wait_clk(4);
      r_scl = 1'b1;
      wait_clk(8);
      r_m_sda_low = 1'b0;
      wait_clk(8);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      r_m_sda_low = ~b;
      wait_clk(4);
      r_scl = 1'b1;
      wait_clk(4);
      s = w_sda;
      wait_clk(4);
      r_scl = 1'b0;
      wait_clk(4);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, ack);
   endtask

   task automatic recv_byte(input logic m_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         b[i] = s;
      end
      bus_bit(m_ack, s);
   endtask

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] rb;
      int         rx0;
      int         ld0;
      logic [7:0] addr_w;

      addr_w        = 8'hA0;
      r_rst         = 1'b0;
      r_scl         = 1'b1;
      r_m_sda_low   = 1'b0;
      u_bus.tx_data = 8'h00;
      wait_clk(3);
      check("rst_rx_data", 32'(u_bus.rx_data), 32'h0);
      check("rst_rx_valid", 32'(u_bus.rx_valid), 32'h0);
      check("rst_tx_load", 32'(u_bus.tx_load), 32'h0);
      check("rst_rw_busy", 32'({u_bus.rw, u_bus.busy}), 32'h0);
      check("rst_sda", 32'(w_sda), 32'h1);
      r_rst = 1'b1;
      wait_clk(4);

      // Write 0x55 to 0x50
      rx0 = n_rx;
      bus_start();
      send_byte(8'hA0, ack);
      check("wr_addr_ack", 32'(ack), 32'h0);
      check("wr_busy", 32'(u_bus.busy), 32'h1);
      check("wr_rw", 32'(u_bus.rw), 32'h0);
      q_rx.push_back(8'h55);
      m_rx_last = 8'h55;
      send_byte(8'h55, ack);
      check("wr_data_ack", 32'(ack), 32'h0);
      bus_stop();
      check("wr_busy_after_stop", 32'(u_bus.busy), 32'h0);
      check("wr_rx_data", 32'(u_bus.rx_data), 32'(m_rx_last));
      check("wr_rx_pulses", 32'(n_rx - rx0), 32'd1);

      // Read C3 (ACK) then 3C (NACK)
      ld0 = n_load;
      u_bus.tx_data = 8'hC3;
      bus_start();
      send_byte(8'hA1, ack);
      check("rd_addr_ack", 32'(ack), 32'h0);
      check("rd_rw", 32'(u_bus.rw), 32'h1);
      check("rd_first_load", 32'(n_load - ld0), 32'd1);
      u_bus.tx_data = 8'h3C;
      recv_byte(1'b0, rb);
      check("rd_byte0", 32'(rb), 32'hC3);
      recv_byte(1'b1, rb);
      check("rd_byte1", 32'(rb), 32'h3C);
      wait_clk(6);
      check("rd_sda_released_after_nack", 32'(w_sda), 32'h1);
      bus_stop();
      check("rd_tx_load_pulses", 32'(n_load - ld0), 32'd2);
      check("rd_busy_after_stop", 32'(u_bus.busy), 32'h0);

      // Address mismatch: 0x51
      rx0 = n_rx;
      bus_start();
      send_byte(8'hA2, ack);
      check("mm_addr_nack", 32'(ack), 32'h1);
      check("mm_busy", 32'(u_bus.busy), 32'h0);
      send_byte(8'h55, ack);
      check("mm_data_nack", 32'(ack), 32'h1);
      bus_stop();
      check("mm_no_rx", 32'(n_rx - rx0), 32'd0);
      check("mm_rx_data_kept", 32'(u_bus.rx_data), 32'(m_rx_last));

      // Write 0x12, repeated START, read one byte
      u_bus.tx_data = 8'h9A;
      bus_start();
      send_byte(addr_w, ack);
      check("sr_wr_ack", 32'(ack), 32'h0);
      q_rx.push_back(8'h12);
      m_rx_last = 8'h12;
      send_byte(8'h12, ack);
      check("sr_data_ack", 32'(ack), 32'h0);
      check("sr_rw_before", 32'(u_bus.rw), 32'h0);
      bus_start();
      check("sr_busy_cleared", 32'(u_bus.busy), 32'h0);
      send_byte(8'hA1, ack);
      check("sr_rd_ack", 32'(ack), 32'h0);
      check("sr_rw_after", 32'(u_bus.rw), 32'h1);
      recv_byte(1'b1, rb);
      check("sr_rd_byte", 32'(rb), 32'h9A);
      bus_stop();
      check("sr_rx_data", 32'(u_bus.rx_data), 32'(m_rx_last));

      // STOP after 4 data bits of a write
      rx0 = n_rx;
      bus_start();
      send_byte(addr_w, ack);
      check("sp_addr_ack", 32'(ack), 32'h0);
      for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
      bus_stop();
      check("sp_no_rx", 32'(n_rx - rx0), 32'd0);
      check("sp_rx_data_kept", 32'(u_bus.rx_data), 32'(m_rx_last));
      check("sp_busy", 32'(u_bus.busy), 32'h0);

      // Reset while the target holds the address ACK
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(addr_w[i], s);
      r_m_sda_low = 1'b0;
      wait_clk(2);
      check("ra_ack_held", 32'(w_sda), 32'h0);
      r_rst = 1'b0;
      wait_clk(1);
      check("ra_sda_released", 32'(w_sda), 32'h1);
      check("ra_outputs", 32'({u_bus.rx_data, u_bus.rx_valid, u_bus.tx_load,
                               u_bus.rw, u_bus.busy}), 32'h0);
      m_rx_last = 8'h00;
      r_rst = 1'b1;
      wait_clk(4);
      bus_start();
      send_byte(addr_w, ack);
      check("ra_reack", 32'(ack), 32'h0);
      bus_stop();
      check("ra_busy_after_stop", 32'(u_bus.busy), 32'h0);

      check("sb_empty", 32'(q_rx.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
